// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the control unit.
// Owns the program counter, reads instruction memory one op_code per cycle,
// and resolves bracket jumps by scanning memory for the matching bracket
// with a nesting-depth counter.
//
// Optional build macro: FETCH_SCAN_CHECK_EN
//   Defined   -> scans that overflow depth, wrap the scan pointer or run for
//                2^PC_WIDTH cycles without a match raise a sticky error and
//                park the unit in HALT.
//   Undefined -> wrap is silent, error is tied low, HALT is never entered.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  OP_WIDTH    = 4,
    parameter int                  DEPTH_WIDTH = 8,
    parameter logic [OP_WIDTH-1:0] OP_OPEN     = 4'hA,
    parameter logic [OP_WIDTH-1:0] OP_CLOSE    = 4'hB,
    parameter logic [OP_WIDTH-1:0] OP_NOP      = 4'h0
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [OP_WIDTH-1:0] imem_data,
    input  logic                bubble,
    input  logic                load_pc,
    input  logic [PC_WIDTH-1:0] pc_in,
    input  logic                store_pc,
    output logic [PC_WIDTH-1:0] pc_out,
    input  logic                cell_zero,
    output logic [OP_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic                scanning,
    output logic                error
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_SCAN_FWD = 2'd1,
        S_SCAN_BWD = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0]    PC_ONE    = PC_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    ptr_q, ptr_d;
    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
    logic [OP_WIDTH-1:0]    instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;

    logic is_open;
    logic is_close;
    logic in_scan;

`ifdef FETCH_SCAN_CHECK_EN
    localparam logic [PC_WIDTH-1:0]    PC_MAX    = {PC_WIDTH{1'b1}};
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = {DEPTH_WIDTH{1'b1}};

    logic                error_q, error_d;
    logic [PC_WIDTH-1:0] scan_cnt_q, scan_cnt_d;
    logic                fault;
`endif

    assign is_open  = (imem_data == OP_OPEN);
    assign is_close = (imem_data == OP_CLOSE);
    assign in_scan  = (state_q == S_SCAN_FWD) || (state_q == S_SCAN_BWD);

    // While scanning, memory is addressed by the scan pointer; otherwise by the PC.
    assign imem_addr   = in_scan ? ptr_q : pc_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign pc_out      = pc_out_q;
    assign scanning    = in_scan;

`ifdef FETCH_SCAN_CHECK_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Next-state logic: load_pc beats bubble, bubble beats the state action.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ptr_d    = ptr_q;
        depth_d  = depth_q;
        instr_d  = instr_q;
        // PC capture is independent of bubble and sees the pre-load PC.
        pc_out_d = store_pc ? pc_q : pc_out_q;
`ifdef FETCH_SCAN_CHECK_EN
        error_d    = error_q;
        scan_cnt_d = scan_cnt_q;
        fault      = 1'b0;
`endif

        if (load_pc) begin
            pc_d    = pc_in;
            state_d = S_FETCH;
            depth_d = '0;
            instr_d = OP_NOP;
`ifdef FETCH_SCAN_CHECK_EN
            scan_cnt_d = '0;
`endif
        end else if (!bubble) begin
            case (state_q)
                S_FETCH: begin
                    if (is_open && cell_zero) begin
                        // Skip forward: PC stays on the bracket until the match is found.
                        instr_d = OP_NOP;
                        depth_d = DEPTH_ONE;
                        ptr_d   = pc_q + PC_ONE;
                        state_d = S_SCAN_FWD;
`ifdef FETCH_SCAN_CHECK_EN
                        scan_cnt_d = '0;
                        if (pc_q == PC_MAX) fault = 1'b1;
`endif
                    end else if (is_close && !cell_zero) begin
                        // Loop back: search backwards for the opening bracket.
                        instr_d = OP_NOP;
                        depth_d = DEPTH_ONE;
                        ptr_d   = pc_q - PC_ONE;
                        state_d = S_SCAN_BWD;
`ifdef FETCH_SCAN_CHECK_EN
                        scan_cnt_d = '0;
                        if (pc_q == '0) fault = 1'b1;
`endif
                    end else begin
                        instr_d = imem_data;
                        pc_d    = pc_q + PC_ONE;
                    end
                end

                S_SCAN_FWD: begin
                    instr_d = OP_NOP;
                    ptr_d   = ptr_q + PC_ONE;
                    if (is_open) begin
                        depth_d = depth_q + DEPTH_ONE;
                    end else if (is_close) begin
                        depth_d = depth_q - DEPTH_ONE;
                        if (depth_q == DEPTH_ONE) begin
                            pc_d    = ptr_q + PC_ONE;
                            state_d = S_FETCH;
                        end
                    end
`ifdef FETCH_SCAN_CHECK_EN
                    scan_cnt_d = scan_cnt_q + PC_ONE;
                    if (state_d != S_FETCH) begin
                        if (is_open && (depth_q == DEPTH_MAX)) fault = 1'b1;
                        if (ptr_q == PC_MAX)                   fault = 1'b1;
                        if (scan_cnt_q == PC_MAX)              fault = 1'b1;
                    end
`endif
                end

                S_SCAN_BWD: begin
                    instr_d = OP_NOP;
                    ptr_d   = ptr_q - PC_ONE;
                    if (is_close) begin
                        depth_d = depth_q + DEPTH_ONE;
                    end else if (is_open) begin
                        depth_d = depth_q - DEPTH_ONE;
                        if (depth_q == DEPTH_ONE) begin
                            pc_d    = ptr_q + PC_ONE;
                            state_d = S_FETCH;
                        end
                    end
`ifdef FETCH_SCAN_CHECK_EN
                    scan_cnt_d = scan_cnt_q + PC_ONE;
                    if (state_d != S_FETCH) begin
                        if (is_close && (depth_q == DEPTH_MAX)) fault = 1'b1;
                        if (ptr_q == '0)                        fault = 1'b1;
                        if (scan_cnt_q == PC_MAX)               fault = 1'b1;
                    end
`endif
                end

                S_HALT: begin
                    instr_d = OP_NOP;
                end

                default: begin
                    state_d = S_FETCH;
                    instr_d = OP_NOP;
                end
            endcase

`ifdef FETCH_SCAN_CHECK_EN
            // A failed scan parks the unit; only reset or load_pc leave HALT.
            if (fault) begin
                error_d = 1'b1;
                state_d = S_HALT;
                pc_d    = pc_q;
                instr_d = OP_NOP;
            end
`endif
        end
    end

    // Control and architectural state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            depth_q  <= '0;
            instr_q  <= OP_NOP;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            depth_q  <= depth_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    // Scan pointer is only meaningful inside a scan, so it carries no reset.
    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
    end

`ifdef FETCH_SCAN_CHECK_EN
    // Sticky fault flag and scan length counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q    <= 1'b0;
            scan_cnt_q <= '0;
        end else begin
            error_q    <= error_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected (op, pc) pairs,
// a negedge monitor pops one whenever a freshly fetched op is presented.
module tb_fetch_unit;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_OPEN  = 4'hA;
    localparam logic [3:0] OP_CLOSE = 4'hB;
    localparam logic [3:0] INC      = 4'h1;
    localparam logic [3:0] DEC      = 4'h2;
    localparam logic [3:0] PSH      = 4'h3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imem_addr;
    logic [3:0]  imem_data;
    logic        bubble = 1'b0;
    logic        load_pc = 1'b0;
    logic [15:0] pc_in = 16'h0;
    logic        store_pc = 1'b0;
    logic [15:0] pc_out;
    logic        cell_zero = 1'b0;
    logic [3:0]  instruction;
    logic [15:0] pc;
    logic        scanning;
    logic        error;

    logic [3:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .bubble(bubble), .load_pc(load_pc), .pc_in(pc_in),
        .store_pc(store_pc), .pc_out(pc_out), .cell_zero(cell_zero),
        .instruction(instruction), .pc(pc), .scanning(scanning), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic bub_edge = 1'b0;

    always @(posedge clk) bub_edge <= bubble;

    // Monitor: a new op is presented when instruction is not NOP and the last edge was not stalled.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!bub_edge && !$isunknown(instruction) && instruction !== OP_NOP) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got op %0h pc %0h, required no instruction", instruction, pc);
            end else begin
                e = sb.pop_front();
                if (instruction !== e.op || pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL sb_instr: got op %0h pc %0h, required op %0h pc %0h",
                             instruction, pc, e.op, e.pc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] p);
        exp_t e;
        e.op = op;
        e.pc = p;
        sb.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = OP_NOP;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_fwd_prog();
        clear_mem();
        mem[0] = OP_OPEN; mem[1] = OP_OPEN; mem[2] = INC;
        mem[3] = OP_CLOSE; mem[4] = OP_CLOSE; mem[5] = DEC;
    endtask

    initial begin
        int sc;
        clear_mem();
        tick();
        tick();
        chk("rst_pc", pc, 16'h0);
        chk("rst_instr", instruction, OP_NOP);
        chk("rst_scanning", scanning, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_pc_out", pc_out, 16'h0);
        reset = 1'b0;

        // Straight-line fetch
        mem[0] = INC; mem[1] = DEC; mem[2] = PSH;
        push(INC, 16'd1); push(DEC, 16'd2); push(PSH, 16'd3);
        tick(); tick(); tick();
        chk("line_pc", pc, 16'd3);
        tick();
        chk("line_drain", sb.size(), 0);

        // Forward jump over a nested pair
        load_fwd_prog();
        cell_zero = 1'b1;
        do_reset();
        sc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (scanning) sc++;
        end
        chk("fwd_scan_cycles", sc, 4);
        chk("fwd_pc", pc, 16'd5);
        chk("fwd_instr_nop", instruction, OP_NOP);
        push(DEC, 16'd6);
        tick();
        chk("fwd_pc_after", pc, 16'd6);
        tick();
        chk("fwd_drain", sb.size(), 0);

        // Backward jump
        clear_mem();
        mem[0] = OP_OPEN; mem[1] = INC; mem[2] = OP_CLOSE;
        cell_zero = 1'b0;
        do_reset();
        push(OP_OPEN, 16'd1); push(INC, 16'd2);
        sc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (scanning) sc++;
        end
        chk("bwd_scan_cycles", sc, 2);
        chk("bwd_pc", pc, 16'd1);
        cell_zero = 1'b1;
        push(INC, 16'd2); push(OP_CLOSE, 16'd3);
        tick(); tick(); tick();
        chk("bwd_drain", sb.size(), 0);

        // Reset in the middle of a forward scan
        load_fwd_prog();
        cell_zero = 1'b1;
        do_reset();
        tick(); tick();
        chk("rstscan_active", scanning, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstscan_pc", pc, 16'h0);
        chk("rstscan_instr", instruction, OP_NOP);
        chk("rstscan_scanning", scanning, 1'b0);

        // Bubble for three cycles during a forward scan
        do_reset();
        tick(); tick();
        chk("bub_ptr_before", imem_addr, 16'd2);
        bubble = 1'b1;
        tick(); tick(); tick();
        bubble = 1'b0;
        chk("bub_ptr_held", imem_addr, 16'd2);
        chk("bub_scanning_held", scanning, 1'b1);
        chk("bub_instr_nop", instruction, OP_NOP);
        tick(); tick();
        chk("bub_ptr_resume", imem_addr, 16'd4);
        chk("bub_still_scanning", scanning, 1'b1);
        tick();
        chk("bub_match_scanning", scanning, 1'b0);
        chk("bub_match_pc", pc, 16'd5);
        push(DEC, 16'd6);
        tick(); tick();
        chk("bub_drain", sb.size(), 0);

        // load_pc aborts a scan
        do_reset();
        tick(); tick();
        load_pc = 1'b1; pc_in = 16'd5;
        tick();
        load_pc = 1'b0;
        chk("abort_scanning", scanning, 1'b0);
        chk("abort_pc", pc, 16'd5);
        chk("abort_instr", instruction, OP_NOP);
        push(DEC, 16'd6);
        tick(); tick();
        chk("abort_drain", sb.size(), 0);

        // load_pc / store_pc collision, then store under bubble
        clear_mem();
        mem[16'h0100] = INC; mem[16'h0101] = DEC;
        cell_zero = 1'b0;
        do_reset();
        load_pc = 1'b1; pc_in = 16'h0010;
        tick();
        chk("ld_pc", pc, 16'h0010);
        pc_in = 16'h0100; store_pc = 1'b1;
        tick();
        load_pc = 1'b0; store_pc = 1'b0;
        chk("coll_pc_out", pc_out, 16'h0010);
        chk("coll_pc", pc, 16'h0100);
        chk("coll_scanning", scanning, 1'b0);
        chk("coll_instr", instruction, OP_NOP);
        push(INC, 16'h0101); push(DEC, 16'h0102);
        tick();
        bubble = 1'b1; store_pc = 1'b1;
        tick();
        bubble = 1'b0; store_pc = 1'b0;
        chk("bubst_pc_out", pc_out, 16'h0101);
        chk("bubst_pc", pc, 16'h0101);
        chk("bubst_instr", instruction, INC);
        tick(); tick();
        chk("coll_drain", sb.size(), 0);

        // PC wrap at the top of the address space
        mem[16'hFFFF] = PSH;
        load_pc = 1'b1; pc_in = 16'hFFFF;
        tick();
        load_pc = 1'b0;
        push(PSH, 16'h0000);
        tick();
        chk("wrap_pc", pc, 16'h0000);
        tick();
        chk("wrap_drain", sb.size(), 0);

`ifdef FETCH_SCAN_CHECK_EN
        // Unmatched forward bracket near the top of memory
        clear_mem();
        mem[16'hFFFE] = OP_OPEN;
        cell_zero = 1'b1;
        load_pc = 1'b1; pc_in = 16'hFFFE;
        tick();
        load_pc = 1'b0;
        tick();
        chk("chk_scan_start", scanning, 1'b1);
        tick();
        chk("chk_error", error, 1'b1);
        chk("chk_halt_scanning", scanning, 1'b0);
        chk("chk_halt_instr", instruction, OP_NOP);
        tick(); tick();
        chk("chk_halt_pc", pc, 16'hFFFE);
        load_pc = 1'b1; pc_in = 16'h0100;
        tick();
        load_pc = 1'b0;
        chk("chk_error_sticky", error, 1'b1);
        chk("chk_load_pc", pc, 16'h0100);
        do_reset();
        chk("chk_error_cleared", error, 1'b0);
`else
        chk("noerr_flag", error, 1'b0);
`endif

        chk("final_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Owns the program counter, reads instruction memory, and presents one op_code per cycle on `instruction`.
- Resolves bracket jumps by scanning instruction memory for the matching bracket using a depth counter.
- Honours the control unit's `bubble`, `load_pc` and `store_pc` outputs.

Parameters:
- PC_WIDTH, 16, program counter / instruction address width.
- OP_WIDTH, 4, op_code width, matching the `definitions` package.
- DEPTH_WIDTH, 8, bracket nesting counter width.
- OP_OPEN, 4'hA, op_code of the forward-bracket instruction.
- OP_CLOSE, 4'hB, op_code of the backward-bracket instruction.
- OP_NOP, 4'h0, op_code driven while no valid instruction is available.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  PC_WIDTH  instruction memory address; combinational from the PC / scan pointer.
- imem_data  in  OP_WIDTH  instruction memory data; combinational, same cycle as imem_addr.
- bubble  in  1  control unit stall; hold PC and instruction.
- load_pc  in  1  load PC from pc_in.
- pc_in  in  PC_WIDTH  PC load value.
- store_pc  in  1  capture current PC into pc_out.
- pc_out  out  PC_WIDTH  last captured PC.
- cell_zero  in  1  datapath: current tape cell == 0.
- instruction  out  OP_WIDTH  registered op_code to the control unit.
- pc  out  PC_WIDTH  current PC.
- scanning  out  1  high while in a SCAN state.
- error  out  1  sticky fault flag; present only with the optional feature, else tied 0.

Behaviour:
- Reset values:
  - pc = 0, pc_out = 0, instruction = OP_NOP, depth = 0, state = FETCH, scanning = 0, error = 0.
- States: FETCH, SCAN_FWD, SCAN_BWD, HALT.
- FETCH:
  - imem_addr = pc.
  - Each cycle: instruction <= imem_data, pc <= pc+1 (mod 2^PC_WIDTH).
  - Fetch-to-instruction latency is 1 cycle.
- Jump triggers in FETCH, evaluated on imem_data:
  - OP_OPEN with cell_zero=1: instruction <= OP_NOP, depth <= 1, scan pointer <= pc+1, go to SCAN_FWD.
  - OP_CLOSE with cell_zero=0: instruction <= OP_NOP, depth <= 1, scan pointer <= pc-1, go to SCAN_BWD.
  - Otherwise a bracket is a plain fetch, forwarded like any op.
- SCAN_FWD:
  - imem_addr = scan pointer; one word examined per cycle.
  - OP_OPEN: depth+1. OP_CLOSE: depth-1.
  - When a CLOSE takes depth 1->0: pc <= ptr+1, return to FETCH.
  - Pointer increments each cycle; instruction held at OP_NOP throughout.
- SCAN_BWD:
  - Mirror of SCAN_FWD: CLOSE depth+1, OPEN depth-1.
  - When an OPEN takes depth 1->0: pc <= ptr+1, return to FETCH.
  - Pointer decrements each cycle.
- scanning = 1 in SCAN_FWD/SCAN_BWD, else 0.
- Priority each cycle, highest first: reset > load_pc > bubble > state action.
  - load_pc (any state): pc <= pc_in, state <= FETCH, depth <= 0, instruction <= OP_NOP. Aborts any scan.
  - bubble: pc, pointer, depth, state and instruction all hold. A scan pauses and resumes on the next cycle without bubble.
- store_pc:
  - pc_out <= pc, as valued at that edge.
  - Independent of bubble.
  - If asserted together with load_pc, the pre-load pc is stored.
- Wrap-around:
  - pc and pointer wrap modulo 2^PC_WIDTH.
  - depth wraps modulo 2^DEPTH_WIDTH.
  - Default build: wrap is silent, no detection.
- HALT:
  - Reachable only with the optional feature.
  - instruction = OP_NOP; pc frozen.
  - Exits only on reset or load_pc (load_pc does not clear error).

Optional Feature:
- Macro: FETCH_SCAN_CHECK_EN.
- Defined:
  - In a SCAN state, error <= 1 and state <= HALT on any of:
    - depth increment from all-ones (overflow);
    - scan pointer wrapping past 0 or past 2^PC_WIDTH-1;
    - a scan lasting 2^PC_WIDTH cycles without a match.
  - error is sticky until reset.
- Undefined:
  - error tied to 0 and HALT unreachable.
  - Wrap behaviour as in Behaviour.

Test Plan:
- Reset mid-scan: reset during SCAN_FWD -> next cycle pc=0, instruction=OP_NOP, scanning=0.
- Straight-line fetch: imem[0..2]={INC,DEC,PSH}, no stalls -> instruction INC, DEC, PSH on cycles 1-3; pc=3.
- Forward jump: imem[0]=OPEN, imem[1]=OPEN, imem[2]=INC, imem[3]=CLOSE, imem[4]=CLOSE, imem[5]=DEC, cell_zero=1 -> scanning high 4 cycles, pc=5, next instruction DEC, no INC emitted.
- Backward jump: imem[0]=OPEN, imem[1]=INC, imem[2]=CLOSE, cell_zero=0 at the CLOSE fetch -> scan to address 0, pc=1, next instruction INC.
- Bubble during scan: assert bubble 3 cycles mid-SCAN_FWD -> pointer and depth hold; match completes exactly 3 cycles later than without bubble.
- load_pc/store_pc collision: pc=0x0010, load_pc=1 with pc_in=0x0100, store_pc=1 -> pc_out=0x0010, pc=0x0100, state=FETCH; with FETCH_SCAN_CHECK_EN, an unmatched OPEN at 0xFFFE -> error=1, HALT.
